// File: rtl/inst_sramlike_axi_rd_bridge_pkg.sv
// Shared constants for the instruction-side SRAM-like to AXI read bridge.
// AXI encodings, SRAM-like size codes and AR FSM state codes. A data-side
// bridge with a W channel reuses the same constants.
package inst_sramlike_axi_rd_bridge_pkg;

    // AXI4 AR-channel encodings
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE   = 8'h00;
    localparam logic [1:0] AXI_LOCK_NORMAL  = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEVICE = 4'h0;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'h0;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam int         AXI_SIZE_W       = 3;

    // SRAM-like size encodings
    localparam int         SRAM_SIZE_W    = 2;
    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    // AR channel FSM state encodings
    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_SEND = 1'b1;

    // SRAM-like size codes map directly onto AXI arsize (bytes = 2**size)
    function automatic logic [AXI_SIZE_W-1:0] sram_to_axi_size(input logic [SRAM_SIZE_W-1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/inst_sramlike_axi_rd_bridge.sv
// Instruction-fetch SRAM-like slave to single-beat AXI4 read master.
// One AR in flight at a time, up to MAX_OUTSTANDING accepted fetches awaiting
// R data; data comes back in acceptance order because the slave is in-order.
module inst_sramlike_axi_rd_bridge
    import inst_sramlike_axi_rd_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] ARID_VAL        = 4'h0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        rresp_err,
    output logic        wr_err
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [1:0]       size_q, size_d;
    logic             rresp_err_q, rresp_err_d;
    logic             wr_err_q, wr_err_d;

    logic             accept;
    logic             r_fire;

    // Write-side and single-beat-only inputs have no function in a read-only in-order bridge
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    // Accept only when no AR is pending and there is room for one more return;
    // the registered count is used so a same-cycle return does not open a slot.
    assign accept            = inst_sram_req & ~inst_sram_wr & (state_q == AR_IDLE)
                             & (cnt_q < CNT_MAX) & ~reset;
    assign inst_sram_addr_ok = accept;

    assign rready            = (cnt_q != '0);
    assign r_fire            = rvalid & rready;
    assign inst_sram_data_ok = r_fire;
    assign inst_sram_rdata   = rdata;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = sram_to_axi_size(size_q);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_DEVICE;
    assign arprot  = AXI_PROT_DEFAULT;
    assign arvalid = (state_q == AR_SEND);

    assign rresp_err = rresp_err_q;
    assign wr_err    = wr_err_q;

    // AR FSM: latch the request on accept, hold it stable until arready
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        araddr_d = araddr_q;
        size_d   = size_q;
        if (state_q == AR_IDLE) begin
            if (accept) begin
                state_d  = AR_SEND;
                araddr_d = inst_sram_addr;
                size_d   = inst_sram_size;
            end
        end else begin
            if (arready) begin
                state_d = AR_IDLE;
            end
        end
    end

    // Outstanding fetch count: up on accept, down on R handshake, both cancel
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !r_fire) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!accept && r_fire) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Sticky error flags: bad read response returned, or a write attempted
    always_comb begin
        rresp_err_d = rresp_err_q | (r_fire && (rresp != AXI_RESP_OKAY));
        wr_err_d    = wr_err_q | (inst_sram_req & inst_sram_wr);
    end

    // State registers with synchronous reset; reset drops all in-flight fetches
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= AR_IDLE;
            cnt_q       <= '0;
            // NOTE: the address/size holding registers are reset too, because araddr/arsize are visible ports with a defined reset value.
            araddr_q    <= '0;
            size_q      <= '0;
            rresp_err_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            araddr_q    <= araddr_d;
            size_q      <= size_d;
            rresp_err_q <= rresp_err_d;
            wr_err_q    <= wr_err_d;
        end
    end

endmodule
